// File: rtl/mld_cyclic_decoder.sv
// Serial one-step majority-logic decoder for an N-bit cyclic code: six check-sums orthogonal on the MSB,
// threshold flip, rotate, N steps per codeword. Define MLD_ERR_COUNT_EN to add the err_count output.
module mld_cyclic_decoder #(
    parameter int              N       = 7,
    parameter logic [6*N-1:0]  CS_MASK = {7'h41, 7'h42, 7'h44, 7'h48, 7'h50, 7'h60},
    parameter int              THRESH  = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] codeword_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] codeword_out,
    output logic         err_flag,
`ifdef MLD_ERR_COUNT_EN
    output logic [$clog2(N+1)-1:0] err_count,
`endif
    output logic         busy
);

    localparam int         STEP_W = $clog2(N);
    localparam int         CNT_W  = $clog2(N + 1);
    localparam logic [2:0] THR    = 3'(THRESH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state_q, state_d;
    logic [N-1:0]        reg_q, reg_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    ecnt_q, ecnt_d;

    logic [5:0]          s;
    logic [2:0]          cnt;
    logic                flip;

    // One shared threshold stage evaluates whichever bit currently sits in the MSB.
    always_comb begin
        s   = '0;
        cnt = '0;
        for (int k = 0; k < 6; k++) begin
            s[k] = ^(reg_q & CS_MASK[k*N +: N]);
            cnt  = cnt + {2'b00, s[k]};
        end
        flip = (cnt >= THR);
    end

    always_comb begin
        state_d = state_q;
        reg_d   = reg_q;
        step_d  = step_q;
        err_d   = err_q;
        ecnt_d  = ecnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    reg_d   = codeword_in;
                    step_d  = '0;
                    err_d   = 1'b0;
                    ecnt_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Corrected MSB rotates into bit 0, so later check-sums see it already fixed.
                reg_d  = {reg_q[N-2:0], reg_q[N-1] ^ flip};
                err_d  = err_q | flip;
                ecnt_d = ecnt_q + CNT_W'(flip);
                step_d = step_q + 1'b1;
                if (step_q == STEP_W'(N - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            reg_q   <= '0;
            step_q  <= '0;
            err_q   <= 1'b0;
            ecnt_q  <= '0;
        end else begin
            state_q <= state_d;
            reg_q   <= reg_d;
            step_q  <= step_d;
            err_q   <= err_d;
            ecnt_q  <= ecnt_d;
        end
    end

    assign in_ready     = (state_q == IDLE);
    assign out_valid    = (state_q == DONE);
    assign busy         = (state_q != IDLE);
    assign codeword_out = reg_q;
    assign err_flag     = err_q;

`ifdef MLD_ERR_COUNT_EN
    assign err_count = ecnt_q;
`else
    logic unused_ecnt;
    assign unused_ecnt = ^ecnt_q;
`endif

endmodule

// File: tb/tb_mld_cyclic_decoder.sv
// Bench for mld_cyclic_decoder: directed codewords, per-cycle comparison against a behavioural model.
module tb_mld_cyclic_decoder;

    localparam int          N    = 7;
    localparam logic [41:0] MASK = {7'h41, 7'h42, 7'h44, 7'h48, 7'h50, 7'h60};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic [6:0] codeword_in = '0;
    logic       in_ready, out_valid, err_flag, busy;
    logic [6:0] codeword_out;
`ifdef MLD_ERR_COUNT_EN
    logic [2:0] err_count;
`endif

    int vectors = 0;
    int fails   = 0;
    int cyc     = 0;

    mld_cyclic_decoder dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .codeword_in(codeword_in),
        .out_valid(out_valid), .out_ready(out_ready), .codeword_out(codeword_out),
        .err_flag(err_flag),
`ifdef MLD_ERR_COUNT_EN
        .err_count(err_count),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Each step treats the register as unrotated: at step t the "MSB" is original bit (6-t)
    // and mask bit i addresses original bit (i-t) mod N.
    function automatic void model_decode(input logic [6:0] cw, output logic [6:0] res, output int nflip);
        logic [6:0] c;
        c = cw;
        nflip = 0;
        for (int t = 0; t < N; t++) begin
            int ones;
            ones = 0;
            for (int k = 0; k < 6; k++) begin
                int par;
                par = 0;
                for (int i = 0; i < N; i++)
                    if (MASK[k*N+i]) par = par ^ int'(c[(i - t + N) % N]);
                ones += par;
            end
            if (ones >= 4) begin
                c[(N - 1 - t + N) % N] = ~c[(N - 1 - t + N) % N];
                nflip++;
            end
        end
        res = c;
    endfunction

    // Behavioural phase model: 0 idle, 1 running, 2 done.
    int         m_ph;
    int         m_cnt;
    logic [6:0] m_src;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ph  <= 0;
            m_cnt <= 0;
            m_src <= '0;
        end else begin
            case (m_ph)
                0: if (in_valid) begin m_ph <= 1; m_cnt <= 0; m_src <= codeword_in; end
                1: if (m_cnt == N - 1) m_ph <= 2; else m_cnt <= m_cnt + 1;
                default: if (out_ready) m_ph <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            logic [6:0] eo;
            int         enf;
            chk("in_ready", 32'(in_ready), 32'(m_ph == 0));
            chk("out_valid", 32'(out_valid), 32'(m_ph == 2));
            chk("busy", 32'(busy), 32'(m_ph != 0));
            if (m_ph == 2) begin
                model_decode(m_src, eo, enf);
                chk("model_cw_out", 32'(codeword_out), 32'(eo));
                chk("model_err_flag", 32'(err_flag), 32'(enf != 0));
`ifdef MLD_ERR_COUNT_EN
                chk("model_err_count", 32'(err_count), 32'(enf));
`endif
            end
        end
    end

    task automatic wait_ir(input string nm);
        int n = 0;
        while (!in_ready && n < 40) begin @(negedge clk); n++; end
        if (!in_ready) chk({nm, "_in_ready_timeout"}, 32'(in_ready), 32'd1);
    endtask

    task automatic wait_ov(input string nm, output int n);
        n = 0;
        while (!out_valid && n < 40) begin @(negedge clk); n++; end
        if (!out_valid) chk({nm, "_out_valid_timeout"}, 32'(out_valid), 32'd1);
    endtask

    task automatic run_one(input string nm, input logic [6:0] cw, input logic [6:0] exp_cw,
                           input logic exp_err, input int exp_ecnt);
        int lat;
        wait_ir(nm);
        codeword_in = cw;
        in_valid    = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_ov(nm, lat);
        chk({nm, "_latency"}, 32'(lat), 32'd7);
        chk({nm, "_cw"}, 32'(codeword_out), 32'(exp_cw));
        chk({nm, "_err"}, 32'(err_flag), 32'(exp_err));
`ifdef MLD_ERR_COUNT_EN
        chk({nm, "_ecnt"}, 32'(err_count), 32'(exp_ecnt));
`else
        if (exp_ecnt < 0) chk({nm, "_ecnt_arg"}, 32'(exp_ecnt), 32'd0);
`endif
        @(negedge clk);
        chk({nm, "_idle_after"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [6:0] r;
        int         nf;
        int         lat;
        int         prev;
        logic [6:0] held;
        logic [6:0] b2b [3];

        // Reset state while rst is held
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cw_out", 32'(codeword_out), 32'd0);
        chk("rst_err", 32'(err_flag), 32'd0);
        rst = 1'b0;

        // Hand-computed pins of the model itself
        model_decode(7'b0000101, r, nf); chk("pin_2err_cw", 32'(r), 32'h00); chk("pin_2err_n", 32'(nf), 32'd2);
        model_decode(7'b0000111, r, nf); chk("pin_3err_cw", 32'(r), 32'h00); chk("pin_3err_n", 32'(nf), 32'd3);
        model_decode(7'b1110001, r, nf); chk("pin_3errb_cw", 32'(r), 32'h7f); chk("pin_3errb_n", 32'(nf), 32'd3);
        model_decode(7'b1111111, r, nf); chk("pin_ones_cw", 32'(r), 32'h7f); chk("pin_ones_n", 32'(nf), 32'd0);

        // Asynchronous abort mid-run
        @(negedge clk);
        codeword_in = 7'b0000101;
        in_valid    = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrun_busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_cw_out", 32'(codeword_out), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_err", 32'(err_flag), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_one("two_err", 7'b0000101, 7'b0000000, 1'b1, 2);
        run_one("zeros", 7'b0000000, 7'b0000000, 1'b0, 0);
        run_one("ones", 7'b1111111, 7'b1111111, 1'b0, 0);
        run_one("three_err_a", 7'b0000111, 7'b0000000, 1'b1, 3);
        run_one("three_err_b", 7'b1110001, 7'b1111111, 1'b1, 3);

        // Back-pressure: output held, input ignored
        out_ready = 1'b0;
        wait_ir("bp");
        codeword_in = 7'b0000111;
        in_valid    = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_ov("bp", lat);
        held = codeword_out;
        chk("bp_cw", 32'(held), 32'h00);
        for (int i = 0; i < 5; i++) begin
            in_valid    = (i % 2 == 0);
            codeword_in = 7'b1010101;
            @(negedge clk);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_cw", 32'(codeword_out), 32'(held));
            chk("bp_hold_err", 32'(err_flag), 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        chk("bp_release_out_valid", 32'(out_valid), 32'd0);

        // Back-to-back with in_valid and out_ready held high
        b2b[0] = 7'b0000101;
        b2b[1] = 7'b1110001;
        b2b[2] = 7'b0000111;
        prev   = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_ir("b2b");
            codeword_in = b2b[i];
            @(negedge clk);
            wait_ov("b2b", lat);
            model_decode(b2b[i], r, nf);
            chk("b2b_cw", 32'(codeword_out), 32'(r));
            if (i > 0) chk("b2b_period", 32'(cyc - prev), 32'd9);
            prev = cyc;
        end
        in_valid = 1'b0;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/mld_cyclic_decoder.md
# mld_cyclic_decoder

Serial cyclic one-step majority-logic decoder controller for an N-bit cyclic codeword. It accepts a received codeword over a valid/ready handshake and loads it into a circular register. It then runs N correction steps, and in each step it:
- forms 6 parity check-sums orthogonal on the MSB,
- evaluates them with a 6-input threshold (majority) stage,
- flips the MSB if the threshold is met,
- rotates the register by one place.

The block sits between the channel/receive buffer and the data sink. It time-shares one 6-input majority evaluation across all N bit positions.

## Interface
Parameters:
- N, 7, codeword length in bits (7..31).
- CS_MASK, {7'h41,7'h42,7'h44,7'h48,7'h50,7'h60}, packed 6×N mask bits. Check-sum k (k=0..5) is the XOR of the register bits selected by CS_MASK[k*N +: N]. Every mask must have bit N-1 set.
- THRESH, 4, minimum number of check-sums equal to 1 that causes the MSB to flip (1..6).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  codeword_in is valid.
- in_ready  output  1  block can accept a codeword (high only in IDLE).
- codeword_in  input  N  received codeword.
- out_valid  output  1  corrected codeword is available.
- out_ready  input  1  sink accepts the output.
- codeword_out  output  N  corrected codeword; driven directly from the working register.
- err_flag  output  1  at least one bit was flipped during this decode.
- busy  output  1  high in RUN and DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: load reg←codeword_in, step←0, err_flag←0, then go to RUN.
- RUN, one step per cycle:
  - s[k] = ^(reg & mask_k) for k=0..5.
  - cnt = popcount(s), 3 bits wide (0..6).
  - flip = (cnt ≥ THRESH).
  - reg ← {reg[N-2:0], reg[N-1]^flip}: the corrected MSB rotates into bit 0.
  - err_flag ← err_flag | flip.
  - step ← step+1.
  - When step==N-1, go to DONE. After exactly N rotations the register is back in its original bit alignment.
- Corrections are fed back: later check-sums use bits that were already corrected.
- DONE:
  - out_valid=1.
  - codeword_out and err_flag stay stable until out_valid&&out_ready, then go to IDLE.
- in_valid is ignored outside IDLE. Back-pressure on out_ready holds the block in DONE indefinitely.
- step counter width is clog2(N). Its reset value is 0.

## Timing
- Reset values (asynchronous, take effect immediately):
  - state=IDLE, reg=0, step=0.
  - in_ready=1, out_valid=0, busy=0, err_flag=0, codeword_out=0.
- Latency: with the load at edge L, RUN occupies edges L+1..L+N and out_valid rises after edge L+N.
  - Minimum throughput is one codeword per N+2 cycles when out_ready is held high.
- A load and an output handshake never occur in the same cycle, so there is no overlap.
- If rst is asserted mid-RUN or in DONE, the block aborts: registers are cleared, the state returns to IDLE, and no out_valid is produced.
- codeword_out and err_flag are registered outputs. in_ready, out_valid and busy are decoded from the state register only.

## Configuration
- Macro MLD_ERR_COUNT_EN:
  - Defined: adds output err_count, width clog2(N+1). It is cleared on load and incremented on every flip in RUN. Its value holds in DONE, and its reset value is 0.
  - Undefined: the port and its counter are absent. All other behaviour is identical.

## Test plan
All scenarios use default parameters (N=7, repetition-code masks, THRESH=4).
- Reset: assert rst mid-RUN after loading 7'b0000101 -> in_ready=1, out_valid=0, codeword_out=0 immediately; the next load decodes normally.
- Error-free codewords: load 7'b0000000 -> out_valid after 7 RUN cycles, codeword_out=7'b0000000, err_flag=0. Load 7'b1111111 -> codeword_out=7'b1111111, err_flag=0.
- Two errors: load 7'b0000101 -> 7'b0000000, err_flag=1, err_count=2 when MLD_ERR_COUNT_EN is defined.
- Three errors: load 7'b0000111 -> 7'b0000000. Load 7'b1110001 -> 7'b1111111. err_count=3 in both cases.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE -> out_valid and codeword_out stay stable and in_valid pulses are ignored. After out_ready=1 there is one handshake, then in_ready=1 on the next cycle.
- Back-to-back: keep in_valid high with out_ready high over 3 codewords -> one output every 9 cycles, each output correct.
